// File: rtl/pkg_sumadores.sv
// Shared types and constants for the adder-exercising sequencer.
// Used by both the LFSR and the FSM/datapath.
package pkg_sumadores;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_WAIT,
        ST_CHECK,
        ST_READ,
        ST_PRESENT,
        ST_DONE
    } estado_t;

    localparam logic [15:0] LFSR_POLY = 16'hB400;

    localparam int IDX_RIZADO = 0;
    localparam int IDX_LOGICO = 1;
    localparam int IDX_LOOK   = 2;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Galois form, shifting right: feedback taps are applied when the lsb leaves.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR operand source; advances once per asserted avanza.
// An all-zero seed would lock the register, so it is replaced by 1.
module lfsr16
    import pkg_sumadores::*;
(
    input  logic        clk,
    input  logic        reset_L,
    input  logic        avanza,
    input  logic [15:0] semilla,
    output logic [15:0] valor
);

    logic [15:0] valor_q;
    logic [15:0] semilla_ok;

    assign semilla_ok = (semilla == 16'h0000) ? 16'h0001 : semilla;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valor_q <= semilla_ok;
        end else if (avanza) begin
            valor_q <= lfsr_next(valor_q);
        end
    end

    assign valor = valor_q;

endmodule

// File: rtl/secuenciador_sumas.sv
// Run controller: clears the transition-counter memory, drives pseudo-random
// operand pairs into three adders, cross-checks them and streams the counters out.
//
// state   | meaning
// IDLE    | waiting for start, memory port in read mode
// CLEAR   | writing 0 to one counter address per cycle
// LOAD    | latch next operand pair from the LFSR
// WAIT    | hold operands SETTLE cycles
// CHECK   | compare the three adder results against the reference sum
// READ    | address counter i, capture its value
// PRESENT | offer counter i on the valid/ready stream
// DONE    | results held until the next start
module secuenciador_sumas
    import pkg_sumadores::*;
#(
    parameter int          NUM_SUMAS = 5000,
    parameter int          SETTLE    = 5,
    parameter int          NUM_CNTR  = 3,
    parameter int          DIR_W     = 2,
    parameter logic [15:0] SEED      = 16'h000A
)(
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    output logic [7:0]       oprA,
    output logic [7:0]       oprB,
    input  logic [7:0]       suma_0,
    input  logic [7:0]       suma_1,
    input  logic [7:0]       suma_2,
    input  logic             carry_0,
    input  logic             carry_1,
    input  logic             carry_2,
    output logic [DIR_W-1:0] mem_dir,
    output logic             mem_LE,
    output logic [31:0]      mem_dato_o,
    output logic             mem_dato_oe,
    input  logic [31:0]      mem_dato_i,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic [DIR_W-1:0] cnt_idx,
    output logic [31:0]      cnt_value,
    output logic [31:0]      sumas_hechas,
    output logic [15:0]      errores,
    output logic [2:0]       err_mask,
    output logic             busy,
    output logic             done
);

    localparam logic [DIR_W-1:0] ULT_DIR    = DIR_W'(NUM_CNTR - 1);
    localparam logic [15:0]      ESPERA_INI = 16'(SETTLE - 1);
    localparam logic [31:0]      SUMAS_FIN  = 32'(NUM_SUMAS);

    estado_t          estado_q;
    logic [7:0]       opr_a_q;
    logic [7:0]       opr_b_q;
    logic [DIR_W-1:0] mem_dir_q;
    logic             mem_le_q;
    logic [31:0]      mem_dato_o_q;
    logic             mem_dato_oe_q;
    logic             cnt_valid_q;
    logic [DIR_W-1:0] cnt_idx_q;
    logic [31:0]      cnt_value_q;
    logic [31:0]      sumas_q;
    logic [15:0]      errores_q;
    logic [2:0]       err_mask_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      espera_q;

    logic [15:0]      lfsr_valor;
    logic             lfsr_avanza;

    logic [8:0]       ref_d;
    logic [2:0]       mism_d;
    logic [16:0]      err_ext_d;
    logic [15:0]      errores_d;
    logic [31:0]      sumas_d;

    assign lfsr_avanza = (estado_q == ST_LOAD);

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset_L (reset_L),
        .avanza  (lfsr_avanza),
        .semilla (SEED),
        .valor   (lfsr_valor)
    );

    always_comb begin
        ref_d                 = {1'b0, opr_a_q} + {1'b0, opr_b_q};
        mism_d                = '0;
        mism_d[IDX_RIZADO]    = ({carry_0, suma_0} != ref_d);
        mism_d[IDX_LOGICO]    = ({carry_1, suma_1} != ref_d);
        mism_d[IDX_LOOK]      = ({carry_2, suma_2} != ref_d);
        err_ext_d             = {1'b0, errores_q} + {15'b0, popcount3(mism_d)};
        errores_d             = err_ext_d[16] ? 16'hFFFF : err_ext_d[15:0];
        sumas_d               = sumas_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            estado_q      <= ST_IDLE;
            opr_a_q       <= '0;
            opr_b_q       <= '0;
            mem_dir_q     <= '0;
            mem_le_q      <= 1'b1;
            mem_dato_o_q  <= '0;
            mem_dato_oe_q <= 1'b0;
            cnt_valid_q   <= 1'b0;
            cnt_idx_q     <= '0;
            cnt_value_q   <= '0;
            sumas_q       <= '0;
            errores_q     <= '0;
            err_mask_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            espera_q      <= '0;
        end else begin
            case (estado_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sumas_q       <= '0;
                        errores_q     <= '0;
                        err_mask_q    <= '0;
                        mem_dir_q     <= '0;
                        mem_le_q      <= 1'b0;
                        mem_dato_oe_q <= 1'b1;
                        mem_dato_o_q  <= '0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        estado_q      <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (mem_dir_q == ULT_DIR) begin
                        mem_dato_oe_q <= 1'b0;
                        estado_q      <= ST_LOAD;
                    end else begin
                        mem_dir_q <= mem_dir_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Read mode is re-enabled a full cycle after the write driver released.
                    opr_a_q  <= lfsr_valor[15:8];
                    opr_b_q  <= lfsr_valor[7:0];
                    mem_le_q <= 1'b1;
                    espera_q <= ESPERA_INI;
                    estado_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (espera_q == 16'd0) begin
                        estado_q <= ST_CHECK;
                    end else begin
                        espera_q <= espera_q - 16'd1;
                    end
                end
                ST_CHECK: begin
                    err_mask_q <= err_mask_q | mism_d;
                    errores_q  <= errores_d;
                    sumas_q    <= sumas_d;
                    if (sumas_d == SUMAS_FIN) begin
                        mem_dir_q <= '0;
                        estado_q  <= ST_READ;
                    end else begin
                        estado_q <= ST_LOAD;
                    end
                end
                ST_READ: begin
                    cnt_value_q <= mem_dato_i;
                    cnt_idx_q   <= mem_dir_q;
                    cnt_valid_q <= 1'b1;
                    estado_q    <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (cnt_ready) begin
                        cnt_valid_q <= 1'b0;
                        if (mem_dir_q == ULT_DIR) begin
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            estado_q <= ST_DONE;
                        end else begin
                            mem_dir_q <= mem_dir_q + 1'b1;
                            estado_q  <= ST_READ;
                        end
                    end
                end
                default: begin
                    estado_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign oprA         = opr_a_q;
    assign oprB         = opr_b_q;
    assign mem_dir      = mem_dir_q;
    assign mem_LE       = mem_le_q;
    assign mem_dato_o   = mem_dato_o_q;
    assign mem_dato_oe  = mem_dato_oe_q;
    assign cnt_valid    = cnt_valid_q;
    assign cnt_idx      = cnt_idx_q;
    assign cnt_value    = cnt_value_q;
    assign sumas_hechas = sumas_q;
    assign errores      = errores_q;
    assign err_mask     = err_mask_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_secuenciador_sumas.sv
// Directed bench: golden run, stuck-at fault on the logic adder, clear/readout with
// backpressure, async reset mid-WAIT, start filtering and error-count saturation.
module tb_secuenciador_sumas;

    localparam int NC     = 3;
    localparam int DW     = 2;
    localparam int NS_SAT = 21850;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_L, start, cnt_ready, fallo_b0, precarga;
    logic [7:0]    oprA, oprB, suma_0, suma_1, suma_2;
    logic          carry_0, carry_1, carry_2;
    logic [DW-1:0] mem_dir, cnt_idx;
    logic          mem_LE, mem_dato_oe, cnt_valid, busy, done;
    logic [31:0]   mem_dato_o, mem_dato_i, cnt_value, sumas_hechas;
    logic [15:0]   errores;
    logic [2:0]    err_mask;

    int checks = 0;
    int failures = 0;

    task automatic revisar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, esp);
        end
    endtask

    // Adders: correct, except optional stuck-at-0 on bit 0 of the logic adder.
    logic [8:0] s_ok;
    assign s_ok = {1'b0, oprA} + {1'b0, oprB};
    assign {carry_0, suma_0} = s_ok;
    assign {carry_1, suma_1} = s_ok & {8'hFF, ~fallo_b0};
    assign {carry_2, suma_2} = s_ok;

    // Counter memory with a transition counter per adder output.
    logic [31:0] mem_q [0:3];
    logic [8:0]  prev_s [0:2];
    assign mem_dato_i = mem_q[mem_dir];

    always @(posedge clk) begin
        if (precarga) begin
            for (int k = 0; k < 4; k++) mem_q[k] <= 32'hDEADBEEF;
        end else if (mem_dato_oe && !mem_LE) begin
            mem_q[mem_dir] <= mem_dato_o;
        end else if (!mem_dato_oe) begin
            if ({carry_0, suma_0} != prev_s[0]) mem_q[0] <= mem_q[0] + 32'd1;
            if ({carry_1, suma_1} != prev_s[1]) mem_q[1] <= mem_q[1] + 32'd1;
            if ({carry_2, suma_2} != prev_s[2]) mem_q[2] <= mem_q[2] + 32'd1;
        end
        prev_s[0] <= {carry_0, suma_0};
        prev_s[1] <= {carry_1, suma_1};
        prev_s[2] <= {carry_2, suma_2};
    end

    int          rd_idx [$];
    logic [31:0] rd_val [$];
    always @(negedge clk) begin
        if (cnt_valid && cnt_ready) begin
            rd_idx.push_back(int'(cnt_idx));
            rd_val.push_back(cnt_value);
        end
    end

    secuenciador_sumas #(
        .NUM_SUMAS(4), .SETTLE(5), .NUM_CNTR(NC), .DIR_W(DW), .SEED(16'h0A0B)
    ) u_dut (
        .clk(clk), .reset_L(reset_L), .start(start),
        .oprA(oprA), .oprB(oprB),
        .suma_0(suma_0), .suma_1(suma_1), .suma_2(suma_2),
        .carry_0(carry_0), .carry_1(carry_1), .carry_2(carry_2),
        .mem_dir(mem_dir), .mem_LE(mem_LE), .mem_dato_o(mem_dato_o),
        .mem_dato_oe(mem_dato_oe), .mem_dato_i(mem_dato_i),
        .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .cnt_idx(cnt_idx),
        .cnt_value(cnt_value), .sumas_hechas(sumas_hechas), .errores(errores),
        .err_mask(err_mask), .busy(busy), .done(done)
    );

    // Second instance: first pair FF+01, every later pair wrong on all adders.
    logic          start_s, cnt_ready_s;
    logic [7:0]    oprA_s, oprB_s, suma_s;
    logic          carry_s, mem_LE_s, mem_dato_oe_s, cnt_valid_s, busy_s, done_s;
    logic [DW-1:0] mem_dir_s, cnt_idx_s;
    logic [31:0]   mem_dato_o_s, mem_dato_i_s, cnt_value_s, sumas_s;
    logic [15:0]   errores_s;
    logic [2:0]    err_mask_s;
    logic [8:0]    ok_s;

    assign cnt_ready_s  = 1'b1;
    assign mem_dato_i_s = 32'h0;
    assign ok_s = {1'b0, oprA_s} + {1'b0, oprB_s};
    assign {carry_s, suma_s} = (oprA_s == 8'hFF && oprB_s == 8'h01) ? ok_s : (ok_s ^ 9'h001);

    secuenciador_sumas #(
        .NUM_SUMAS(NS_SAT), .SETTLE(1), .NUM_CNTR(NC), .DIR_W(DW), .SEED(16'hFF01)
    ) u_sat (
        .clk(clk), .reset_L(reset_L), .start(start_s),
        .oprA(oprA_s), .oprB(oprB_s),
        .suma_0(suma_s), .suma_1(suma_s), .suma_2(suma_s),
        .carry_0(carry_s), .carry_1(carry_s), .carry_2(carry_s),
        .mem_dir(mem_dir_s), .mem_LE(mem_LE_s), .mem_dato_o(mem_dato_o_s),
        .mem_dato_oe(mem_dato_oe_s), .mem_dato_i(mem_dato_i_s),
        .cnt_valid(cnt_valid_s), .cnt_ready(cnt_ready_s), .cnt_idx(cnt_idx_s),
        .cnt_value(cnt_value_s), .sumas_hechas(sumas_s), .errores(errores_s),
        .err_mask(err_mask_s), .busy(busy_s), .done(done_s)
    );

    task automatic revisar_reset(input string p);
        revisar({p, "_oprA"}, oprA, 0);
        revisar({p, "_oprB"}, oprB, 0);
        revisar({p, "_mem_dir"}, mem_dir, 0);
        revisar({p, "_mem_LE"}, mem_LE, 1);
        revisar({p, "_mem_oe"}, mem_dato_oe, 0);
        revisar({p, "_mem_dato_o"}, mem_dato_o, 0);
        revisar({p, "_cnt_valid"}, cnt_valid, 0);
        revisar({p, "_cnt_idx"}, cnt_idx, 0);
        revisar({p, "_cnt_value"}, cnt_value, 0);
        revisar({p, "_sumas"}, sumas_hechas, 0);
        revisar({p, "_errores"}, errores, 0);
        revisar({p, "_err_mask"}, err_mask, 0);
        revisar({p, "_busy"}, busy, 0);
        revisar({p, "_done"}, done, 0);
    endtask

    task automatic pulso_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic leer_uno(input int idx, input logic [31:0] val, input int hold);
        for (int i = 0; i < 300 && !cnt_valid; i++) @(negedge clk);
        revisar($sformatf("valid_idx%0d", idx), cnt_valid, 1);
        revisar($sformatf("cnt_idx%0d", idx), cnt_idx, idx);
        revisar($sformatf("cnt_value%0d", idx), cnt_value, val);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            revisar($sformatf("bp_valid_c%0d", i), cnt_valid, 1);
            revisar($sformatf("bp_idx_c%0d", i), cnt_idx, idx);
            revisar($sformatf("bp_value_c%0d", i), cnt_value, val);
        end
        cnt_ready = 1'b1;
        @(negedge clk) cnt_ready = 1'b0;
    endtask

    task automatic esperar_done(input string tag, input int lim);
        int n;
        n = 0;
        while (done !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        revisar(tag, done, 1);
    endtask

    initial begin
        int n;
        logic [7:0] a_r2, b_r2;
        reset_L = 1'b0; start = 1'b0; start_s = 1'b0; cnt_ready = 1'b0;
        fallo_b0 = 1'b0; precarga = 1'b0;
        a_r2 = '0; b_r2 = '0;
        repeat (3) @(negedge clk);
        revisar_reset("rst");
        reset_L = 1'b1;
        @(negedge clk) precarga = 1'b1;
        @(negedge clk) precarga = 1'b0;

        // Run 1: golden, memory preloaded with DEADBEEF, backpressure on idx 1.
        pulso_start();
        revisar("r1_busy", busy, 1);
        revisar("r1_clr_LE", mem_LE, 0);
        revisar("r1_clr_oe", mem_dato_oe, 1);
        revisar("r1_clr_dir0", mem_dir, 0);
        repeat (3) @(negedge clk);
        revisar("r1_oe_off", mem_dato_oe, 0);
        revisar("r1_LE_still0", mem_LE, 0);
        revisar("r1_mem0_clr", mem_q[0], 0);
        revisar("r1_mem1_clr", mem_q[1], 0);
        revisar("r1_mem2_clr", mem_q[2], 0);
        @(negedge clk);
        revisar("r1_oprA", oprA, 8'h0A);
        revisar("r1_oprB", oprB, 8'h0B);
        revisar("r1_LE_read", mem_LE, 1);
        leer_uno(0, 32'd4, 0);
        leer_uno(1, 32'd4, 10);
        leer_uno(2, 32'd4, 0);
        revisar("r1_done", done, 1);
        revisar("r1_busy_end", busy, 0);
        revisar("r1_sumas", sumas_hechas, 4);
        revisar("r1_errores", errores, 0);
        revisar("r1_mask", err_mask, 3'b000);

        // Run 2: stuck-at-0 on suma_1[0], ready tied high, latency, ignored start.
        fallo_b0 = 1'b1;
        cnt_ready = 1'b1;
        @(negedge clk);
        rd_idx.delete();
        rd_val.delete();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            start = (n == 10);
            if (n == 5) begin
                a_r2 = oprA;
                b_r2 = oprB;
            end
        end
        start = 1'b0;
        revisar("r2_latencia", n, 38);
        revisar("r2_oprA", a_r2, 8'h8F);
        revisar("r2_oprB", b_r2, 8'h20);
        revisar("r2_sumas", sumas_hechas, 4);
        revisar("r2_errores", errores, 4);
        revisar("r2_mask", err_mask, 3'b010);
        revisar("r2_nrd", rd_idx.size(), 3);
        for (int k = 0; k < 3 && k < rd_idx.size(); k++) begin
            revisar($sformatf("r2_rd_idx%0d", k), rd_idx[k], k);
            revisar($sformatf("r2_rd_val%0d", k), rd_val[k], 32'd4);
        end

        // Run 3: LFSR continues, then async reset mid-WAIT.
        fallo_b0 = 1'b0;
        pulso_start();
        repeat (4) @(negedge clk);
        revisar("r3_oprA", oprA, 8'h08);
        revisar("r3_oprB", oprB, 8'hF2);
        repeat (2) @(negedge clk);
        revisar("r3_busy_wait", busy, 1);
        reset_L = 1'b0;
        #1;
        revisar_reset("midrst");
        @(negedge clk) reset_L = 1'b1;

        // Run 4: reset reseeds the LFSR.
        pulso_start();
        repeat (4) @(negedge clk);
        revisar("r4_oprA", oprA, 8'h0A);
        revisar("r4_oprB", oprB, 8'h0B);
        esperar_done("r4_done", 300);
        revisar("r4_sumas", sumas_hechas, 4);
        revisar("r4_errores", errores, 0);

        // Saturation instance.
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        n = 0;
        while (sumas_s != 32'd1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        revisar("sat_first_sumas", sumas_s, 1);
        revisar("sat_first_oprA", oprA_s, 8'hFF);
        revisar("sat_first_oprB", oprB_s, 8'h01);
        revisar("sat_carry_ok_err", errores_s, 0);
        revisar("sat_carry_ok_mask", err_mask_s, 3'b000);
        n = 0;
        while (done_s !== 1'b1 && n < 70000) begin
            @(negedge clk);
            n++;
        end
        revisar("sat_done", done_s, 1);
        revisar("sat_sumas", sumas_s, NS_SAT);
        revisar("sat_errores", errores_s, 16'hFFFF);
        revisar("sat_mask", err_mask_s, 3'b111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
